// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_if : requester (I/D) and backing-memory signals of mem_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        err;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
        output mem_req, mem_wr, mem_addr, mem_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
        input  mem_req, mem_wr, mem_addr, mem_wdata, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : D-priority arbiter with I starvation guard for one memory port
// Optional MEM_TIMEOUT_EN adds a BUSY watchdog with sticky err.   Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_t      state_q, state_n;
    logic        owner_d_q, owner_d_n;
    logic [3:0]  starve_q, starve_n;
    logic        mem_req_q, mem_req_n;
    logic        mem_wr_q, mem_wr_n;
    logic [15:0] mem_addr_q, mem_addr_n;
    logic [15:0] mem_wdata_q, mem_wdata_n;
    logic        i_done_q, i_done_n;
    logic        d_done_q, d_done_n;
    logic [15:0] i_rdata_q, i_rdata_n;
    logic [15:0] d_rdata_q, d_rdata_n;
    logic        timeout_hit;
    logic        grant_i;
    logic [15:0] resp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= 16'h0000;
            d_rdata_q   <= 16'h0000;
        end else begin
            state_q     <= state_n;
            owner_d_q   <= owner_d_n;
            starve_q    <= starve_n;
            mem_req_q   <= mem_req_n;
            mem_wr_q    <= mem_wr_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            i_done_q    <= i_done_n;
            d_done_q    <= d_done_n;
            i_rdata_q   <= i_rdata_n;
            d_rdata_q   <= d_rdata_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        owner_d_n   = owner_d_q;
        starve_n    = starve_q;
        mem_req_n   = mem_req_q;
        mem_wr_n    = mem_wr_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        i_done_n    = 1'b0;
        d_done_n    = 1'b0;
        i_rdata_n   = i_rdata_q;
        d_rdata_n   = d_rdata_q;
        grant_i     = 1'b0;
        resp_data   = 16'h0000;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // I wins only when alone or when D has used up its run of grants
                    grant_i     = bus.i_req && (!bus.d_req || (starve_q == STARVE_LIMIT));
                    owner_d_n   = !grant_i;
                    mem_req_n   = 1'b1;
                    mem_wr_n    = grant_i ? 1'b0 : bus.d_wr;
                    mem_addr_n  = grant_i ? bus.i_addr : bus.d_addr;
                    mem_wdata_n = grant_i ? 16'h0000 : bus.d_wdata;
                    if (grant_i || !bus.i_req) begin
                        starve_n = 4'd0;
                    end else if (starve_q != STARVE_LIMIT) begin
                        starve_n = starve_q + 4'd1;
                    end
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack || timeout_hit) begin
                    // A watchdog completion and a D write both return zero data
                    if (bus.mem_ack && !(owner_d_q && mem_wr_q)) begin
                        resp_data = bus.mem_rdata;
                    end
                    mem_req_n = 1'b0;
                    if (owner_d_q) begin
                        d_rdata_n = resp_data;
                        d_done_n  = 1'b1;
                    end else begin
                        i_rdata_n = resp_data;
                        i_done_n  = 1'b1;
                    end
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tcnt_q;
    logic       err_q;

    assign timeout_hit = (state_q == BUSY) && !bus.mem_ack && (tcnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            if (state_q != BUSY) begin
                tcnt_q <= 8'd0;
            end else if (!bus.mem_ack) begin
                tcnt_q <= tcnt_q + 8'd1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    // TIMEOUT has no effect without the watchdog
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign bus.err        = 1'b0;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : scoreboard bench for mem_arbiter (grant and done queues)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    typedef struct packed {
        logic        is_d;
        logic [15:0] rdata;
    } done_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } grant_t;

    logic clk;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(
        .STARVE_MAX (3),
        .TIMEOUT    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests;
    int fails;
    done_t  exp_done[$];
    grant_t exp_grant[$];
    grant_t cur_grant;

    logic        mem_en;
    int          ack_delay;
    logic [15:0] mem_data;
    logic        model_ack;
    logic [15:0] model_rdata;
    logic        stray_ack;
    logic        req_prev;
    int          cyc;
    int          last_ack_cyc;

    assign bus.mem_ack   = model_ack | stray_ack;
    assign bus.mem_rdata = model_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_ack && bus.mem_req) last_ack_cyc <= cyc;
    end

    // Memory model: ack ack_delay negedges after mem_req is first seen
    initial begin
        int wcnt;
        wcnt = 0;
        model_ack = 1'b0;
        model_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            model_ack = 1'b0;
            if (mem_en && bus.mem_req) begin
                if (wcnt >= ack_delay) begin
                    model_ack   = 1'b1;
                    model_rdata = mem_data;
                    wcnt        = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Grant monitor: checks each new memory request and its stability
    initial begin
        grant_t g;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !req_prev) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                end else begin
                    g = exp_grant.pop_front();
                    cur_grant = g;
                    chk("grant_wr", 32'(bus.mem_wr), 32'(g.wr));
                    chk("grant_addr", 32'(bus.mem_addr), 32'(g.addr));
                    if (g.wr) chk("grant_wdata", 32'(bus.mem_wdata), 32'(g.wdata));
                end
            end else if (bus.mem_req && req_prev) begin
                chk("busy_hold_addr", {bus.mem_wr, 15'd0, bus.mem_addr},
                    {cur_grant.wr, 15'd0, cur_grant.addr});
            end
            req_prev = bus.mem_req;
        end
    end

    // Done monitor
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (bus.i_done || bus.d_done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", {30'd0, bus.d_done, bus.i_done}, 32'd0);
                end else begin
                    e = exp_done.pop_front();
                    chk("done_one_side", 32'(bus.i_done & bus.d_done), 32'd0);
                    chk("done_side", 32'(bus.d_done), 32'(e.is_d));
                    chk("done_rdata", 32'(bus.d_done ? bus.d_rdata : bus.i_rdata), 32'(e.rdata));
                end
            end
        end
    end

    task automatic wait_dones(input int n, input int budget, input string name);
        int seen;
        seen = 0;
        for (int k = 0; k < budget && seen < n; k++) begin
            @(negedge clk);
            if (bus.i_done || bus.d_done) seen++;
        end
        if (seen < n) chk({name, "_timeout"}, 32'(seen), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        chk({tag, "_mem_wr"},    32'(bus.mem_wr),    32'd0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_dones"},     {30'd0, bus.i_done, bus.d_done}, 32'd0);
        chk({tag, "_i_rdata"},   32'(bus.i_rdata),   32'd0);
        chk({tag, "_d_rdata"},   32'(bus.d_rdata),   32'd0);
        chk({tag, "_err"},       32'(bus.err),       32'd0);
    endtask

    initial begin
        int a1;
        int busy_cycles;
        int cnt;
        tests = 0;
        fails = 0;
        cyc = 0;
        last_ack_cyc = 0;
        mem_en = 1'b1;
        ack_delay = 4;
        mem_data = 16'h0000;
        stray_ack = 1'b0;
        rst = 1'b1;
        bus.i_req = 1'b0;
        bus.i_addr = 16'h0000;
        bus.d_req = 1'b0;
        bus.d_wr = 1'b0;
        bus.d_addr = 16'h0000;
        bus.d_wdata = 16'h0000;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // I-only read
        mem_data = 16'hA5A5;
        exp_grant.push_back('{wr: 1'b0, addr: 16'h0040, wdata: 16'h0000});
        exp_done.push_back('{is_d: 1'b0, rdata: 16'hA5A5});
        bus.i_req = 1'b1;
        bus.i_addr = 16'h0040;
        wait_dones(1, 40, "i_read");
        bus.i_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("i_rdata_held", 32'(bus.i_rdata), 32'h0000_A5A5);

        // D write
        mem_data = 16'h1234;
        exp_grant.push_back('{wr: 1'b1, addr: 16'h1000, wdata: 16'hBEEF});
        exp_done.push_back('{is_d: 1'b1, rdata: 16'h0000});
        bus.d_req = 1'b1;
        bus.d_wr = 1'b1;
        bus.d_addr = 16'h1000;
        bus.d_wdata = 16'hBEEF;
        wait_dones(1, 40, "d_write");
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("i_rdata_kept_over_d", 32'(bus.i_rdata), 32'h0000_A5A5);

        // Contention: D,D,D,I,D,D,D,I
        mem_data = 16'h7777;
        ack_delay = 1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3 || k == 7) begin
                exp_grant.push_back('{wr: 1'b0, addr: 16'h0100, wdata: 16'h0000});
                exp_done.push_back('{is_d: 1'b0, rdata: 16'h7777});
            end else begin
                exp_grant.push_back('{wr: 1'b1, addr: 16'h2000, wdata: 16'h1111});
                exp_done.push_back('{is_d: 1'b1, rdata: 16'h0000});
            end
        end
        bus.d_addr = 16'h2000;
        bus.d_wdata = 16'h1111;
        bus.i_addr = 16'h0100;
        bus.d_req = 1'b1;
        bus.i_req = 1'b1;
        wait_dones(8, 200, "contention");
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back D reads: next mem_req 3 cycles after the ack
        mem_data = 16'hC0DE;
        ack_delay = 2;
        for (int k = 0; k < 2; k++) begin
            exp_grant.push_back('{wr: 1'b0, addr: 16'h3000, wdata: 16'h0000});
            exp_done.push_back('{is_d: 1'b1, rdata: 16'hC0DE});
        end
        bus.d_wr = 1'b0;
        bus.d_addr = 16'h3000;
        bus.d_req = 1'b1;
        wait_dones(1, 40, "b2b_first");
        a1 = last_ack_cyc;
        cnt = 0;
        while (!bus.mem_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b_spacing", 32'(cyc - a1), 32'd3);
        wait_dones(1, 40, "b2b_second");
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no ack at all
        mem_en = 1'b0;
        exp_grant.push_back('{wr: 1'b0, addr: 16'h0050, wdata: 16'h0000});
        exp_done.push_back('{is_d: 1'b0, rdata: 16'h0000});
        bus.i_addr = 16'h0050;
        bus.i_req = 1'b1;
        busy_cycles = 0;
        cnt = 0;
        while (!bus.i_done && cnt < 60) begin
            @(negedge clk);
            if (bus.mem_req) busy_cycles++;
            cnt++;
        end
        bus.i_req = 1'b0;
        chk("timeout_busy_cycles", 32'(busy_cycles), 32'd8);
        chk("timeout_err_set", 32'(bus.err), 32'd1);
        repeat (5) @(negedge clk);
        chk("timeout_err_sticky", 32'(bus.err), 32'd1);
`else
        busy_cycles = 0;
        chk("err_tied_low", 32'(bus.err), 32'(busy_cycles));
`endif

        // Async reset mid-BUSY, then a stray ack in IDLE
        mem_en = 1'b0;
        exp_grant.push_back('{wr: 1'b0, addr: 16'h4000, wdata: 16'h0000});
        bus.d_wr = 1'b0;
        bus.d_addr = 16'h4000;
        bus.d_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.mem_req), 32'd1);
        bus.d_req = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.i_done || bus.d_done || bus.mem_req) cnt++;
        end
        chk("no_activity_after_reset", 32'(cnt), 32'd0);

        chk("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
